icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, read-only instruction cache serving the fetch stage. Fetch presents a PC every cycle. The cache returns the 32-bit instruction and a hit flag in the same cycle. On a miss it refills one line from the memory port, one 32-bit word per transaction, then installs the line. It also reports misaligned-PC and access-fault conditions so fetch can raise the matching exceptions.

## Interface

Parameters:
- NUM_LINES, 64: number of lines; power of 2, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, ≥2.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high; clock CLK.
- PC  in  64  fetch address, sampled every cycle.
- flush  in  1  invalidate all lines (fence.i); one-cycle pulse.
- cache_hit  out  1  instruction is valid for the current PC (combinational).
- instruction  out  32  instruction word for PC; 32'h0000_0013 (NOP) when cache_hit=0.
- misaligned  out  1  PC[1:0]!=0 (combinational).
- fault  out  1  last refill of PC's line returned an error.
- mem_req  out  1  read request valid.
- mem_addr  out  64  word-aligned read address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- mem_err  in  1  bus error; qualified by mem_rvalid.

## Operation

- Address split: offset = PC[OW+1:2] with OW = log2(LINE_WORDS); index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: valid[NUM_LINES], tag array, and data array of NUM_LINES*LINE_WORDS words. All arrays are flops with combinational read.
- Hit: cache_hit = valid[index] && tag match && !misaligned && state==IDLE. Otherwise cache_hit=0.
- FSM states:
  - IDLE: if the PC misses and is aligned and is not the fault line, latch line_addr = PC with offset and byte bits zeroed, set word counter=0, go to REQ. Misaligned PCs never start a refill.
  - REQ: mem_req=1, mem_addr = line_addr + 4*count. On mem_gnt go to WAIT. mem_req and mem_addr stay stable until mem_gnt.
  - WAIT: on mem_rvalid, write mem_rdata into the fill buffer at count. Set err_seen if mem_err. If count==LINE_WORDS-1, go to INSTALL; else increment count and go to REQ.
  - INSTALL: one cycle.
    - If !err_seen and !flush_seen: write the buffer to the data array, write the tag, set valid[index].
    - If err_seen: record fault_line=line_addr and fault_v=1, leave valid unchanged.
    - Clear err_seen and flush_seen, go to IDLE.
- Refill always runs to completion for the latched line, regardless of PC changes. Only one request is ever outstanding.
- fault = fault_v && (PC line address == fault_line). A hit or miss on any other line leaves fault_v set. fault_v clears on flush, reset, or a successful install of fault_line.
- flush:
  - In IDLE or INSTALL: all valid bits clear next edge. Flush takes priority over an install in the same cycle.
  - In REQ/WAIT: valid bits clear and flush_seen is set, so the in-flight line is discarded at INSTALL.
  - Always clears fault_v.

## Timing

- Reset values:
  - state=IDLE, all valid=0, fault_v=0, count=0, err_seen=0, flush_seen=0.
  - mem_req=0, mem_addr=0, cache_hit=0, fault=0.
  - instruction=NOP.
- Hit latency: 0 cycles (combinational from PC).
- Miss detected in IDLE in cycle T: REQ starts in T+1.
- Ideal memory (mem_gnt in the REQ cycle, mem_rvalid the cycle after): per word REQ→WAIT = 2 cycles. INSTALL at T+1+2*LINE_WORDS. cache_hit=1 at T+2+2*LINE_WORDS if PC is unchanged; with defaults, T+10.
- mem_rvalid arriving outside WAIT is ignored.
- reset mid-refill: FSM returns to IDLE and mem_req drops on the next edge. No line is installed. A late mem_rvalid after reset is ignored.
- Index wrap: the last line (index NUM_LINES-1) and the last word (offset LINE_WORDS-1) must map correctly. The final word's address is line_addr+4*(LINE_WORDS-1).

## Test plan

- Cold miss then hit:
  - Stimulus: reset, PC=0x1000, ideal memory returning word=addr.
  - Required: mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C. cache_hit=1 ten cycles after the miss with instruction=0x1000. PC=0x100C then hits with 0x100C and no mem_req.
- Conflict eviction:
  - Stimulus: fill 0x1000, then PC = 0x1000 + 16*NUM_LINES (0x1400).
  - Required: miss, refill, valid line replaced. Returning to 0x1000 misses again.
- Misaligned:
  - Stimulus: PC=0x1002.
  - Required: misaligned=1, cache_hit=0, mem_req stays 0 indefinitely.
- Access fault:
  - Stimulus: mem_err=1 on the second word of the 0x2000 refill.
  - Required: all four words are still requested. No install. fault=1 while PC is in 0x2000–0x200C; fault=0 at PC=0x3000. flush clears fault, after which PC=0x2000 re-triggers a refill.
- Flush during refill:
  - Stimulus: flush pulse while in WAIT for 0x4000, with 0x1000 previously cached.
  - Required: refill completes but 0x4000 is not valid afterward. 0x1000 now misses.
- Reset mid-refill and backpressure:
  - Stimulus: hold mem_gnt=0 for 5 cycles, checking that mem_req and mem_addr stay stable. Then assert reset during WAIT.
  - Required: next cycle mem_req=0 and state IDLE. A stray mem_rvalid has no effect. The subsequent miss restarts at word 0.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hit path from PC, word-by-word
// line refill over a single-outstanding request/grant/rvalid memory port.
module icache_dm #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] PC,
  input  logic        flush,
  output logic        cache_hit,
  output logic [31:0] instruction,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [1:0]  dbg_state
);

  localparam int OW      = $clog2(LINE_WORDS);
  localparam int IW      = $clog2(NUM_LINES);
  localparam int TAG_LSB = OW + IW + 2;
  localparam int TW      = 64 - TAG_LSB;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_INSTALL = 2'd3
  } state_t;

  state_t state, state_d;

  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES*LINE_WORDS];
  logic [31:0]          fill_buf [LINE_WORDS];

  logic [63:0]   line_addr;
  logic [OW-1:0] count;
  logic          err_seen;
  logic          flush_seen;
  logic [63:0]   fault_line;
  logic          fault_v;

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic [63:0]   pc_line;
  logic [IW-1:0] line_idx;
  logic [TW-1:0] line_tag;
  logic          tag_match;
  logic          on_fault_line;
  logic          start_fill;
  logic          last_word;
  logic          install_ok;

  assign pc_off   = PC[OW+1:2];
  assign pc_idx   = PC[TAG_LSB-1:OW+2];
  assign pc_tag   = PC[63:TAG_LSB];
  assign pc_line  = {PC[63:OW+2], {(OW+2){1'b0}}};
  assign line_idx = line_addr[TAG_LSB-1:OW+2];
  assign line_tag = line_addr[63:TAG_LSB];

  assign misaligned    = (PC[1:0] != 2'b00);
  assign tag_match     = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign on_fault_line = fault_v && (pc_line == fault_line);
  assign cache_hit     = tag_match && !misaligned && (state == S_IDLE);
  assign instruction   = cache_hit ? data_arr[{pc_idx, pc_off}] : NOP;
  assign fault         = on_fault_line;

  // A known-faulting line is not refetched until flush or a clean refill clears it.
  assign start_fill = (state == S_IDLE) && !tag_match && !misaligned && !on_fault_line;
  assign last_word  = (count == OW'(LINE_WORDS - 1));
  assign install_ok = (state == S_INSTALL) && !err_seen && !flush_seen && !flush;

  // Memory handshake: mem_req/mem_addr are held stable until the cycle mem_gnt is high;
  // exactly one read is outstanding, and mem_rvalid (with mem_err) is honoured only in S_WAIT.
  assign mem_req   = (state == S_REQ);
  assign mem_addr  = mem_req ? (line_addr + 64'({count, 2'b00})) : 64'd0;
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (start_fill) state_d = S_REQ;
      S_REQ:     if (mem_gnt) state_d = S_WAIT;
      S_WAIT:    if (mem_rvalid) state_d = last_word ? S_INSTALL : S_REQ;
      S_INSTALL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      valid      <= '0;
      fault_v    <= 1'b0;
      fault_line <= 64'd0;
      line_addr  <= 64'd0;
      count      <= '0;
      err_seen   <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (start_fill) begin
            line_addr <= pc_line;
            count     <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (mem_err) err_seen <= 1'b1;
            if (!last_word) count <= count + OW'(1);
          end
        end
        S_INSTALL: begin
          err_seen   <= 1'b0;
          flush_seen <= 1'b0;
          if (install_ok) begin
            valid[line_idx] <= 1'b1;
            if (fault_v && (line_addr == fault_line)) fault_v <= 1'b0;
          end
          if (err_seen) begin
            fault_line <= line_addr;
            fault_v    <= 1'b1;
          end
        end
        default: ;
      endcase
      // Placed last so a flush overrides any install or fault capture in the same cycle.
      if (flush) begin
        valid   <= '0;
        fault_v <= 1'b0;
        if ((state == S_REQ) || (state == S_WAIT)) flush_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == S_WAIT) && mem_rvalid) fill_buf[count] <= mem_rdata;
    if (install_ok) begin
      tag_arr[line_idx] <= line_tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_arr[{line_idx, OW'(w)}] <= fill_buf[w];
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a small memory model answers each read with its own address,
// and every grant's address is matched against an expected-address queue.
module tb_icache_dm;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int ST_IDLE = 0, ST_REQ = 1, ST_WAIT = 2, ST_INSTALL = 3;

  // clock / reset
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic [63:0] PC;
  logic        flush;
  logic        cache_hit;
  logic [31:0] instruction;
  logic        misaligned;
  logic        fault;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [1:0]  dbg_state;

  icache_dm #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .CLK(CLK), .reset(reset), .PC(PC), .flush(flush),
    .cache_hit(cache_hit), .instruction(instruction), .misaligned(misaligned), .fault(fault),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .dbg_state(dbg_state)
  );

  // memory model: grant while enabled, answer the cycle after a grant with data = address
  logic        gnt_en, resp_en, stray_rvalid, err_en;
  logic [63:0] err_addr;
  logic        pend_v;
  logic [63:0] pend_addr;

  assign mem_gnt    = mem_req && gnt_en;
  assign mem_rvalid = (pend_v && resp_en) || stray_rvalid;
  assign mem_rdata  = stray_rvalid ? 32'hBAD0_BAD0 : pend_addr[31:0];
  assign mem_err    = pend_v && err_en && (pend_addr == err_addr);

  always @(posedge CLK) begin
    if (reset) begin
      pend_v <= 1'b0;
    end else begin
      if (pend_v && resp_en) pend_v <= 1'b0;
      if (mem_req && mem_gnt) begin
        pend_v    <= 1'b1;
        pend_addr <= mem_addr;
      end
    end
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!reset && mem_req && mem_gnt) begin
      logic [63:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("grant_addr", mem_addr, e);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Miss on base in cycle T, expect INSTALL at T+9 and a hit at T+10, then probe the line.
  task automatic fill_line(input logic [63:0] base, input logic [63:0] probe);
    for (int w = 0; w < 4; w++) exp_q.push_back(base + 64'(4 * w));
    PC = base;
    #1;
    check("fill_miss", cache_hit, 0);
    repeat (9) tick();
    check("fill_install_state", dbg_state, ST_INSTALL);
    check("fill_install_nohit", cache_hit, 0);
    tick();
    check("fill_hit", cache_hit, 1);
    check("fill_instr", instruction, base[31:0]);
    PC = probe;
    #1;
    check("probe_hit", cache_hit, 1);
    check("probe_instr", instruction, probe[31:0]);
    check("probe_no_req", mem_req, 0);
  endtask

  initial begin
    reset = 1'b1; PC = 64'd0; flush = 1'b0;
    gnt_en = 1'b1; resp_en = 1'b1; stray_rvalid = 1'b0; err_en = 1'b0; err_addr = 64'd0;
    repeat (3) tick();
    check("rst_hit", cache_hit, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_fault", fault, 0);
    check("rst_instr", instruction, NOP);
    check("rst_state", dbg_state, ST_IDLE);

    // cold miss then hit, last word of line
    reset = 1'b0;
    fill_line(64'h1000, 64'h100C);
    // last index of the array
    fill_line(64'h13F0, 64'h13FC);
    PC = 64'h1004;
    #1;
    check("keep_hit", cache_hit, 1);
    check("keep_instr", instruction, 32'h1004);

    // conflict eviction on index 0
    fill_line(64'h1400, 64'h1404);
    PC = 64'h1000;
    #1;
    check("evicted_miss", cache_hit, 0);
    fill_line(64'h1000, 64'h1008);

    // misaligned PC never refills
    PC = 64'h1002;
    #1;
    check("mis_flag", misaligned, 1);
    check("mis_hit", cache_hit, 0);
    check("mis_instr", instruction, NOP);
    repeat (20) tick();
    check("mis_no_req", mem_req, 0);
    check("mis_state", dbg_state, ST_IDLE);

    // access fault on second word of 0x2000
    err_en = 1'b1; err_addr = 64'h2004;
    for (int w = 0; w < 4; w++) exp_q.push_back(64'h2000 + 64'(4 * w));
    PC = 64'h2000;
    #1;
    repeat (10) tick();
    err_en = 1'b0;
    check("flt_hit", cache_hit, 0);
    check("flt_fault", fault, 1);
    check("flt_state", dbg_state, ST_IDLE);
    PC = 64'h200C;
    #1;
    check("flt_fault_lastword", fault, 1);
    repeat (3) tick();
    check("flt_no_refetch", mem_req, 0);
    PC = 64'h3000;
    #1;
    check("flt_other_line", fault, 0);
    fill_line(64'h3000, 64'h3008);
    check("flt_other_after_fill", fault, 0);
    PC = 64'h2008;
    #1;
    check("flt_persists", fault, 1);
    PC = 64'h2000;
    flush = 1'b1;
    #1;
    check("flt_before_flush", fault, 1);
    tick();
    flush = 1'b0;
    check("flt_cleared", fault, 0);
    fill_line(64'h2000, 64'h2004);
    PC = 64'h3004;
    #1;
    check("flushed_line_miss", cache_hit, 0);

    // flush while a refill of 0x4000 is in WAIT
    fill_line(64'h1000, 64'h1000);
    for (int w = 0; w < 4; w++) exp_q.push_back(64'h4000 + 64'(4 * w));
    PC = 64'h4000;
    #1;
    tick();
    tick();
    check("fl_in_wait", dbg_state, ST_WAIT);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (7) tick();
    check("fl_idle", dbg_state, ST_IDLE);
    check("fl_discarded", cache_hit, 0);
    PC = 64'h1000;
    #1;
    check("fl_old_line_miss", cache_hit, 0);
    fill_line(64'h1000, 64'h100C);

    // backpressure, then reset while waiting for data
    gnt_en = 1'b0;
    exp_q.push_back(64'h5000);
    PC = 64'h5000;
    #1;
    tick();
    check("bp_req", mem_req, 1);
    check("bp_addr", mem_addr, 64'h5000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_req_hold", mem_req, 1);
      check("bp_addr_hold", mem_addr, 64'h5000);
    end
    gnt_en = 1'b1; resp_en = 1'b0;
    tick();
    check("bp_wait", dbg_state, ST_WAIT);
    check("bp_req_drop", mem_req, 0);
    tick();
    reset = 1'b1;
    PC = 64'h5002;
    tick();
    check("rr_req", mem_req, 0);
    check("rr_state", dbg_state, ST_IDLE);
    reset = 1'b0; resp_en = 1'b1; stray_rvalid = 1'b1;
    tick();
    stray_rvalid = 1'b0;
    check("stray_state", dbg_state, ST_IDLE);
    check("stray_req", mem_req, 0);
    check("stray_hit", cache_hit, 0);
    fill_line(64'h5000, 64'h500C);

    tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
